// File: rtl/tdm_arb_pkg.sv
// tdm_arb_pkg: shared FSM state type and phase encoding helper for the TDM slot arbiter
package tdm_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GUARD} arb_state_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/tdm_slot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set req after index last (wrapping)
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int OWNER_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last,
  output logic               valid,
  output logic [OWNER_W-1:0] idx
);
  // scan from farthest to nearest so the nearest set request after last wins
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(last) + k) % NUM_REQ]) idx = OWNER_W'((int'(last) + k) % NUM_REQ);
  end
  assign valid = |req;
endmodule

// File: rtl/tdm_slot_arbiter.sv
// tdm_slot_arbiter: round-robin time-boxed arbiter with guard gap; TDM_ARB_GRAY_PHASE_EN selects Gray-coded phase output
module tdm_slot_arbiter
  import tdm_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SLOT_LEN = 6,
  localparam int OWNER_W = $clog2(NUM_REQ),
  localparam int PHASE_W = $clog2(SLOT_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [OWNER_W-1:0] owner,
  output logic [PHASE_W-1:0] phase,
  output logic               slot_start,
  output logic               timeout,
  output logic               busy
);
  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(SLOT_LEN - 1);
  arb_state_t state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic timeout_q, timeout_d, pick_valid, in_grant, start, at_limit, slot_end;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req),
    .last(last_q),
    .valid(pick_valid),
    .idx(pick_idx)
  );

  // state and slot bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      phase_q   <= '0;
      last_q    <= OWNER_W'(NUM_REQ - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      phase_q   <= phase_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  // next state: slot ends on done, dropped request or phase limit; guard gap always follows
  always_comb begin
    in_grant  = state_q == GRANT;
    start     = en && pick_valid;
    at_limit  = phase_q == PHASE_MAX;
    slot_end  = done[owner_q] || !req[owner_q] || at_limit;
    state_d   = in_grant ? (slot_end ? GUARD : GRANT) : (start ? GRANT : IDLE);
    owner_d   = (!in_grant && start) ? pick_idx : owner_q;
    phase_d   = (in_grant && !slot_end) ? phase_q + 1'b1 : '0;
    last_d    = (in_grant && slot_end) ? owner_q : last_q;
    timeout_d = in_grant && at_limit && !done[owner_q] && req[owner_q];
  end

  // outputs decoded purely from registered state
  always_comb begin
    busy       = state_q == GRANT;
    grant      = busy ? NUM_REQ'(1) << owner_q : '0;
    slot_start = busy && phase_q == '0;
    timeout    = timeout_q;
    owner      = owner_q;
`ifdef TDM_ARB_GRAY_PHASE_EN
    phase      = PHASE_W'(bin2gray(32'(phase_q)));
`else
    phase      = phase_q;
`endif
  end
endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// tb_tdm_slot_arbiter: table-driven cycle vectors with an expected-output scoreboard queue
module tb_tdm_slot_arbiter;
  typedef struct {
    logic       rst, en;
    logic [3:0] req, done, g;
    logic [1:0] o;
    logic [2:0] p;
    logic       ss, to, b;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [3:0] req = '0, done = '0, grant;
  logic [1:0] owner;
  logic [2:0] phase;
  logic slot_start, timeout, busy;
  vec_t vecs[$];
  logic [11:0] expq[$];
  int checks = 0, errors = 0;
  tdm_slot_arbiter #(.NUM_REQ(4), .SLOT_LEN(6)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .grant(grant), .owner(owner), .phase(phase),
    .slot_start(slot_start), .timeout(timeout), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] enc(input logic [2:0] p);
`ifdef TDM_ARB_GRAY_PHASE_EN
    return p ^ (p >> 1);
`else
    return p;
`endif
  endfunction
  function automatic void add(input logic r, e, input logic [3:0] rq, dn, g,
                              input logic [1:0] o, input logic [2:0] p, input logic ss, to, b);
    vec_t v;
    v.rst = r; v.en = e; v.req = rq; v.done = dn; v.g = g;
    v.o = o; v.p = p; v.ss = ss; v.to = to; v.b = b;
    vecs.push_back(v);
  endfunction
  initial begin
    logic [11:0] got, exp;
    for (int i = 0; i < 3; i++) add(1, 1, 4'b1111, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) add(0, 1, 4'b0100, 0, 4'b0100, 2, 3'(k), k == 0, 0, 1);
    add(0, 1, 4'b0100, 0, 0, 2, 0, 0, 1, 0);
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 0, 1, 0, 1);
    add(0, 1, 4'b0000, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 0, 2, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) add(0, 1, 4'b0100, 0, 4'b0100, 2, 3'(k), k == 0, 0, 1);
    add(0, 1, 4'b0100, 4'b0100, 0, 2, 0, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 0, 2, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 4'b0100, 0, 4'b0100, 2, 3'(k), k == 0, 0, 1);
    add(0, 1, 4'b0000, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 4'b0001, 0, 0, 1, 0, 1);
    add(0, 0, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 0, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 0);
    add(0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 4'b0001, 0, 0, 1, 0, 1);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 1, 4'b0100, 0, 4'b0100, 2, 3'(k), k == 0, 0, 1);
    add(1, 1, 4'b0101, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0101, 0, 4'b0001, 0, 0, 1, 0, 1);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      add(0, 1, 4'b1111, 0, 4'b0001 << (k % 4), 2'(k % 4), 0, 1, 0, 1);
      add(0, 1, 4'b1111, 0, 4'b0001 << (k % 4), 2'(k % 4), 1, 0, 0, 1);
      add(0, 1, 4'b1111, 4'b0001 << (k % 4), 0, 2'(k % 4), 0, 0, 0, 0);
    end
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; req = vecs[i].req; done = vecs[i].done;
      expq.push_back({vecs[i].g, vecs[i].o, enc(vecs[i].p), vecs[i].ss, vecs[i].to, vecs[i].b});
      @(posedge clk);
      #1;
      got = {grant, owner, phase, slot_start, timeout, busy};
      exp = expq.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d {grant,owner,phase,ss,to,busy}: got %b_%b_%b_%b%b%b expected %b_%b_%b_%b%b%b",
                 i, got[11:8], got[7:6], got[5:3], got[2], got[1], got[0],
                 exp[11:8], exp[7:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
    end
    @(negedge clk);
    rst = 1; en = 1; req = 4'b1111; done = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({grant, owner, phase, slot_start, timeout, busy} !== 12'b0) begin
      errors++;
      $display("FAIL reset state: grant=%b owner=%0d phase=%b ss=%b to=%b busy=%b",
               grant, owner, phase, slot_start, timeout, busy);
    end
    @(negedge clk);
    rst = 0; req = 4'b0100;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (timeout !== 1'b1 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL expired wait: timeout=%b grant=%b", timeout, grant);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
